// File: rtl/ram_if_pkg.sv
// Shared definitions for the ram_if_2 front end: bus widths, timeout default
// and the arbiter FSM encoding.
package ram_if_pkg;

    localparam int ADDR_W_DEF  = 13;
    localparam int DATA_W_DEF  = 64;
    localparam int TIMEOUT_DEF = 1023;
    localparam int TO_W_DEF    = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin picker; on a tie the port not named by last wins.
// Purely combinational; the caller owns the pointer register.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       en,
    output logic [1:0] gnt,
    output logic       next_last
);

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
        next_last = (|gnt) ? gnt[1] : last;
    end

endmodule

// File: rtl/ram_if_arbiter.sv
// Two-port round-robin arbiter and transaction sequencer in front of ram_if_2.
// One transaction at a time: IDLE -> ISSUE -> RESP -> GAP -> IDLE.
module ram_if_arbiter
    import ram_if_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int TO_W    = TO_W_DEF
) (
    input  logic              cache_clk,
    input  logic              areset_n,
    input  logic              req0_rd,
    input  logic              req0_wr,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ack,
    output logic              req0_err,
    output logic [DATA_W-1:0] req0_rdata,
    input  logic              req1_rd,
    input  logic              req1_wr,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ack,
    output logic              req1_err,
    output logic [DATA_W-1:0] req1_rdata,
    output logic              if_rd,
    output logic              if_wr,
    output logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_wdata,
    input  logic [DATA_W-1:0] if_rdata,
    input  logic              if_ack,
    output logic [1:0]        grant,
    output logic              busy
);

    state_t            state, state_d;
    logic              last_q;
    logic [TO_W-1:0]   to_cnt;
    logic              err_q;
    logic [1:0]        gnt;
    logic              next_last;
    logic              timeout_hit;
    logic              sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    rr_arb2 u_arb (
        .req       ({req1_rd | req1_wr, req0_rd | req0_wr}),
        .last      (last_q),
        .en        (state == ST_IDLE),
        .gnt       (gnt),
        .next_last (next_last)
    );

    assign sel_wr    = gnt[1] ? req1_wr    : req0_wr;
    assign sel_addr  = gnt[1] ? req1_addr  : req0_addr;
    assign sel_wdata = gnt[1] ? req1_wdata : req0_wdata;

    // Fires on the TIMEOUT-th ISSUE cycle without an ack.
    assign timeout_hit = (to_cnt >= TO_W'(TIMEOUT - 1));

    always_ff @(posedge cache_clk or negedge areset_n) begin
        if (!areset_n) state <= ST_IDLE;
        else           state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE:  if (|gnt) state_d = ST_ISSUE;
            ST_ISSUE: if (if_ack || timeout_hit) state_d = ST_RESP;
            ST_RESP:  state_d = ST_GAP;
            ST_GAP:   if (!if_ack) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != ST_IDLE);
        req0_ack = (state == ST_RESP) && grant[0];
        req1_ack = (state == ST_RESP) && grant[1];
        req0_err = req0_ack && err_q;
        req1_err = req1_ack && err_q;
    end

    always_ff @(posedge cache_clk or negedge areset_n) begin
        if (!areset_n) begin
            if_rd      <= 1'b0;
            if_wr      <= 1'b0;
            if_addr    <= '0;
            if_wdata   <= '0;
            grant      <= 2'b00;
            last_q     <= 1'b1;
            to_cnt     <= '0;
            err_q      <= 1'b0;
            req0_rdata <= '0;
            req1_rdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|gnt) begin
                        if_rd    <= ~sel_wr;
                        if_wr    <= sel_wr;
                        if_addr  <= sel_addr;
                        if_wdata <= sel_wdata;
                        grant    <= gnt;
                        last_q   <= next_last;
                        to_cnt   <= '0;
                        err_q    <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    if (if_ack) begin
                        if_rd <= 1'b0;
                        if_wr <= 1'b0;
                        err_q <= 1'b0;
                        if (if_rd && grant[0]) req0_rdata <= if_rdata;
                        if (if_rd && grant[1]) req1_rdata <= if_rdata;
                    end else begin
                        if (to_cnt != TO_W'(TIMEOUT)) to_cnt <= to_cnt + TO_W'(1);
                        if (timeout_hit) begin
                            if_rd <= 1'b0;
                            if_wr <= 1'b0;
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    if (!if_ack) grant <= 2'b00;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_if_arbiter.sv
// Directed bench for ram_if_arbiter with TIMEOUT shortened to 8 cycles.
module tb_ram_if_arbiter;

    localparam int AW = 13;
    localparam int DW = 64;

    logic          cache_clk = 1'b0;
    logic          areset_n  = 1'b0;
    logic          req0_rd = 0, req0_wr = 0, req1_rd = 0, req1_wr = 0;
    logic [AW-1:0] req0_addr = '0, req1_addr = '0;
    logic [DW-1:0] req0_wdata = '0, req1_wdata = '0;
    logic          req0_ack, req0_err, req1_ack, req1_err;
    logic [DW-1:0] req0_rdata, req1_rdata;
    logic          if_rd, if_wr, if_ack = 1'b0;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_wdata, if_rdata = '0;
    logic [1:0]    grant;
    logic          busy;

    int errors = 0;
    int checks = 0;
    logic [DW-1:0] exp_rd0 = '0, exp_rd1 = '0;

    ram_if_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8), .TO_W(4)) dut (
        .cache_clk(cache_clk), .areset_n(areset_n),
        .req0_rd(req0_rd), .req0_wr(req0_wr), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req0_ack(req0_ack), .req0_err(req0_err), .req0_rdata(req0_rdata),
        .req1_rd(req1_rd), .req1_wr(req1_wr), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .req1_ack(req1_ack), .req1_err(req1_err), .req1_rdata(req1_rdata),
        .if_rd(if_rd), .if_wr(if_wr), .if_addr(if_addr), .if_wdata(if_wdata),
        .if_rdata(if_rdata), .if_ack(if_ack), .grant(grant), .busy(busy)
    );

    always #5 cache_clk = ~cache_clk;

    task automatic tick();
        @(posedge cache_clk);
        #1;
    endtask

    task automatic test_reset();
        logic [8:0] outs;
        #1;
        outs = {if_rd, if_wr, busy, grant, req0_ack, req1_ack, req0_err, req1_err};
        checks++; if (outs !== 9'd0) begin errors++; $display("FAIL reset_outs: got %b expected 0", outs); end
        tick(); areset_n = 1'b1;
        req1_wr = 1'b1; req1_addr = 13'h0AAA; req1_wdata = 64'h55;
        tick();
        checks++; if ({if_wr, grant} !== 3'b110) begin errors++; $display("FAIL reset_pre_wr: got %b expected 110", {if_wr, grant}); end
        tick();
        areset_n = 1'b0;
        #1;
        outs = {if_rd, if_wr, busy, grant, req0_ack, req1_ack, req0_err, req1_err};
        checks++; if (outs !== 9'd0) begin errors++; $display("FAIL reset_mid_issue: got %b expected 0", outs); end
        req1_wr = 1'b0;
        tick(); areset_n = 1'b1;
        req0_rd = 1'b1; req1_rd = 1'b1;
        tick();
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL reset_tie_grant: got %b expected 01", grant); end
        areset_n = 1'b0; req0_rd = 1'b0; req1_rd = 1'b0;
        #2; areset_n = 1'b1;
    endtask

    task automatic test_single_read();
        req0_rd = 1'b1; req0_addr = 13'h010F;
        tick();
        checks++; if ({if_rd, if_wr, grant, busy} !== 5'b10011) begin errors++; $display("FAIL rd_issue: got %b expected 10011", {if_rd, if_wr, grant, busy}); end
        checks++; if (if_addr !== 13'h010F) begin errors++; $display("FAIL rd_addr: got %h expected 010f", if_addr); end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if ({if_rd, req0_ack} !== 2'b10) begin errors++; $display("FAIL rd_hold%0d: got %b expected 10", i, {if_rd, req0_ack}); end
        end
        if_ack = 1'b1; if_rdata = 64'h90786F5E4D3C2B1A;
        tick();
        exp_rd0 = 64'h90786F5E4D3C2B1A;
        checks++; if ({if_rd, req0_ack, req0_err, req1_ack} !== 4'b0100) begin errors++; $display("FAIL rd_resp: got %b expected 0100", {if_rd, req0_ack, req0_err, req1_ack}); end
        checks++; if (req0_rdata !== exp_rd0) begin errors++; $display("FAIL rd_data: got %h expected %h", req0_rdata, exp_rd0); end
        if_ack = 1'b0; req0_rd = 1'b0;
        tick();
        checks++; if ({req0_ack, busy} !== 2'b01) begin errors++; $display("FAIL rd_gap: got %b expected 01", {req0_ack, busy}); end
        tick();
        checks++; if ({busy, grant} !== 3'b000) begin errors++; $display("FAIL rd_idle: got %b expected 000", {busy, grant}); end
    endtask

    task automatic test_write_held_ack();
        int pulses = 0;
        req1_wr = 1'b1; req1_rd = 1'b1; req1_addr = 13'h1ABC; req1_wdata = 64'h1234567890ABCDEF;
        tick();
        checks++; if ({if_rd, if_wr, grant} !== 4'b0110) begin errors++; $display("FAIL wr_issue: got %b expected 0110", {if_rd, if_wr, grant}); end
        checks++; if (if_wdata !== 64'h1234567890ABCDEF) begin errors++; $display("FAIL wr_data: got %h expected 1234567890abcdef", if_wdata); end
        if_ack = 1'b1; if_rdata = 64'hDEAD;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (req1_ack) pulses++;
            if (i == 0) begin
                req1_wr = 1'b0; req1_rd = 1'b0;
                checks++; if ({if_wr, req1_ack, req1_err, req0_ack} !== 4'b0100) begin errors++; $display("FAIL wr_resp: got %b expected 0100", {if_wr, req1_ack, req1_err, req0_ack}); end
            end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy%0d: got %b expected 1", i, busy); end
        end
        if_ack = 1'b0;
        tick();
        checks++; if ({busy, grant} !== 3'b000) begin errors++; $display("FAIL wr_idle: got %b expected 000", {busy, grant}); end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL wr_pulses: got %0d expected 1", pulses); end
        checks++; if (req1_rdata !== exp_rd1) begin errors++; $display("FAIL wr_rdata_kept: got %h expected %h", req1_rdata, exp_rd1); end
    endtask

    task automatic test_contention();
        logic [1:0]    exp_g = 2'b01;
        logic [DW-1:0] d;
        req0_addr = 13'h0100; req1_addr = 13'h0200;
        req0_rd = 1'b1; req1_rd = 1'b1;
        for (int t = 0; t < 4; t++) begin
            tick();
            checks++; if ({grant, if_rd} !== {exp_g, 1'b1}) begin errors++; $display("FAIL cont_grant%0d: got %b expected %b", t, {grant, if_rd}, {exp_g, 1'b1}); end
            checks++; if (if_addr !== (exp_g[0] ? 13'h0100 : 13'h0200)) begin errors++; $display("FAIL cont_addr%0d: got %h", t, if_addr); end
            d = 64'hC0DE000000000000 | 64'(t);
            if_ack = 1'b1; if_rdata = d;
            tick();
            if (exp_g[0]) exp_rd0 = d; else exp_rd1 = d;
            checks++; if ({req1_ack, req0_ack, req1_err, req0_err} !== {exp_g, 2'b00}) begin errors++; $display("FAIL cont_ack%0d: got %b expected %b00", t, {req1_ack, req0_ack, req1_err, req0_err}, exp_g); end
            checks++; if ({req0_rdata, req1_rdata} !== {exp_rd0, exp_rd1}) begin errors++; $display("FAIL cont_data%0d: got %h %h expected %h %h", t, req0_rdata, req1_rdata, exp_rd0, exp_rd1); end
            if_ack = 1'b0;
            if (exp_g[0]) req0_rd = 1'b0; else req1_rd = 1'b0;
            tick();
            checks++; if ({if_rd, busy} !== 2'b01) begin errors++; $display("FAIL cont_gap%0d: got %b expected 01", t, {if_rd, busy}); end
            tick();
            checks++; if ({if_rd, busy} !== 2'b00) begin errors++; $display("FAIL cont_idle%0d: got %b expected 00", t, {if_rd, busy}); end
            if (exp_g[0]) req0_rd = 1'b1; else req1_rd = 1'b1;
            exp_g = {exp_g[0], exp_g[1]};
        end
        req0_rd = 1'b0; req1_rd = 1'b0;
    endtask

    task automatic test_timeout();
        req0_rd = 1'b1; req0_addr = 13'h0077;
        tick();
        for (int k = 1; k < 8; k++) begin
            tick();
            checks++; if ({if_rd, req0_ack} !== 2'b10) begin errors++; $display("FAIL to_wait%0d: got %b expected 10", k, {if_rd, req0_ack}); end
        end
        tick();
        checks++; if ({if_rd, req0_ack, req0_err} !== 3'b011) begin errors++; $display("FAIL to_resp: got %b expected 011", {if_rd, req0_ack, req0_err}); end
        checks++; if (req0_rdata !== exp_rd0) begin errors++; $display("FAIL to_rdata_kept: got %h expected %h", req0_rdata, exp_rd0); end
        req0_rd = 1'b0;
        tick();
        checks++; if ({req0_ack, req0_err, busy} !== 3'b001) begin errors++; $display("FAIL to_gap: got %b expected 001", {req0_ack, req0_err, busy}); end
        if_ack = 1'b1; if_rdata = 64'hBAD0BAD0BAD0BAD0;
        tick();
        checks++; if ({req0_ack, req1_ack, busy} !== 3'b001) begin errors++; $display("FAIL to_late_ack: got %b expected 001", {req0_ack, req1_ack, busy}); end
        if_ack = 1'b0;
        tick();
        checks++; if ({req0_ack, busy, grant} !== 4'b0000) begin errors++; $display("FAIL to_idle: got %b expected 0000", {req0_ack, busy, grant}); end
        checks++; if (req0_rdata !== exp_rd0) begin errors++; $display("FAIL to_late_data: got %h expected %h", req0_rdata, exp_rd0); end
    endtask

    task automatic test_ack_at_timeout();
        req0_rd = 1'b1; req0_addr = 13'h0033;
        tick();
        for (int k = 1; k < 8; k++) tick();
        if_ack = 1'b1; if_rdata = 64'h0F1E2D3C4B5A6978;
        tick();
        exp_rd0 = 64'h0F1E2D3C4B5A6978;
        checks++; if ({req0_ack, req0_err} !== 2'b10) begin errors++; $display("FAIL coinc_ack: got %b expected 10", {req0_ack, req0_err}); end
        checks++; if (req0_rdata !== exp_rd0) begin errors++; $display("FAIL coinc_data: got %h expected %h", req0_rdata, exp_rd0); end
        if_ack = 1'b0; req0_rd = 1'b0;
        tick(); tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL coinc_idle: got %b expected 0", busy); end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_read();
        test_write_held_ack();
        test_contention();
        test_timeout();
        test_ack_at_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_if_arbiter.md
Name: ram_if_arbiter

Overview:
- Two-port round-robin arbiter and transaction sequencer in front of ram_if_2, in the cache_clk domain.
- Lets two cache-side requesters share one ram_if_2 line port. Port 0 is the instruction-fetch fill path; port 1 is the data fill/writeback path.
- Latches the winning request and drives ram_if_2 rd/wr/addr_c/wdata_c. Waits for its ack, then returns a one-cycle response or a timeout error to the winner.

Parameters:
ADDR_W, 13, line/byte address width; matches ram_if_2 addr_c
DATA_W, 64, cache line width; matches ram_if_2 wdata_c/rdata_c
TIMEOUT, 1023, cache_clk cycles in ISSUE without if_ack before the transaction is aborted
TO_W, 10, timeout counter width; must satisfy 2**TO_W > TIMEOUT

Ports:
cache_clk  in  1  sole clock; all logic on rising edge
areset_n  in  1  asynchronous, active-low reset
req0_rd  in  1  port 0 read-line request; level, held until req0_ack
req0_wr  in  1  port 0 write-line request; level, held until req0_ack
req0_addr  in  ADDR_W  port 0 address
req0_wdata  in  DATA_W  port 0 write data
req0_ack  out  1  one-cycle completion pulse to port 0
req0_err  out  1  qualifies req0_ack; 1 = timed out
req0_rdata  out  DATA_W  read data; valid while req0_ack=1
req1_rd, req1_wr, req1_addr, req1_wdata, req1_ack, req1_err, req1_rdata: same as port 0
if_rd  out  1  to ram_if_2 rd
if_wr  out  1  to ram_if_2 wr
if_addr  out  ADDR_W  to ram_if_2 addr_c
if_wdata  out  DATA_W  to ram_if_2 wdata_c
if_rdata  in  DATA_W  from ram_if_2 rdata_c
if_ack  in  1  from ram_if_2 ack; level or pulse, synchronous to cache_clk
grant  out  2  one-hot owner of the current transaction; 00 when idle
busy  out  1  1 in every state except IDLE

Behaviour:
- Reset (areset_n=0, asynchronous, including mid-transaction):
  - all outputs 0; state=IDLE; timeout counter=0; last-grant pointer=1, so port 0 wins the first tie.
  - A transaction in flight is abandoned. The requester gets no ack.
- A port is requesting when rd|wr=1. If rd=wr=1, the op is write.
- States: IDLE, ISSUE, RESP, GAP.
- IDLE:
  - No request: stay in IDLE.
  - One port requesting: grant it.
  - Both requesting: grant the port not equal to the last-grant pointer.
  - On grant (edge N):
    - register op, addr and wdata of the winner into the if_* registers;
    - set grant one-hot and update the pointer;
    - clear the timeout counter;
    - go to ISSUE. if_rd or if_wr is high from N+1.
- ISSUE:
  - if_rd/if_wr, if_addr and if_wdata are held constant.
  - Requester inputs are ignored after grant.
  - if_ack=1 at edge M:
    - drop if_rd/if_wr;
    - capture if_rdata into the winner's reqN_rdata (reads only; unchanged on writes);
    - go to RESP.
  - Otherwise the counter increments. When the counter equals TIMEOUT, drop if_rd/if_wr, set err and go to RESP.
  - If if_ack and timeout coincide, if_ack wins and err=0.
- RESP:
  - exactly one cycle: reqN_ack=1 for the winner only; reqN_err as decided in ISSUE.
  - Then go to GAP.
  - The requester must drop rd/wr within one cycle of seeing ack.
- GAP:
  - minimum one cycle.
  - Stay while if_ack=1, so a held ram_if_2 ack is not taken for the next transaction.
  - Go to IDLE when if_ack=0. grant returns to 00 on entry to IDLE.
- if_ack in IDLE, RESP or GAP: no effect other than extending GAP. A late ack after a timeout is absorbed this way.
- reqN_rdata holds its last value between reads; reqN_err is 0 whenever reqN_ack=0.
- Minimum latency: grant edge N, if_ack sampled at N+1, reqN_ack at N+2.
- Back-to-back throughput: one transaction per 4 cycles minimum. Round-robin alternates under continuous contention, so no port is starved.
- The timeout counter saturates at TIMEOUT and never wraps.

Decomposition:
- Shared package ram_if_pkg:
  - state encoding constants ST_IDLE, ST_ISSUE, ST_RESP, ST_GAP;
  - ADDR_W/DATA_W defaults, shared with ram_if_2;
  - TIMEOUT default.
- One natural sub-module, rr_arb2: 2-request round-robin picker.
  - Inputs: req[1:0], last pointer, enable.
  - Outputs: one-hot gnt[1:0] and next pointer; purely combinational.
- FSM, latches, timeout counter and response mux stay in ram_if_arbiter.

Test Plan:
1. Reset mid-ISSUE:
   - stimulus: port 1 write in flight, pulse areset_n low for 1 cycle;
   - required: if_wr, busy, grant and req1_ack are 0 immediately; after release, the next tie grants port 0.
2. Single read:
   - stimulus: req0_rd=1, req0_addr=13'h010F; if_ack=1 three cycles after if_rd rises, if_rdata=64'h90786F5E4D3C2B1A;
   - required: if_rd=1 with if_addr=13'h010F, held until the ack edge; then one-cycle req0_ack with req0_rdata=64'h90786F5E4D3C2B1A and req0_err=0.
3. Write with a held ack:
   - stimulus: req1_wr=1, req1_wdata=64'h1234567890ABCDEF; if_ack held high for 4 cycles;
   - required: if_wdata matches the write data; req1_ack pulses once; busy stays 1 until the cycle after if_ack falls.
4. Contention:
   - stimulus: both ports request reads continuously for 4 transactions;
   - required: grant sequence is 01, 10, 01, 10, each ack goes only to the granted port, and there is at least one cycle of if_rd=0 between transactions.
5. Timeout:
   - stimulus: TIMEOUT=8, req0_rd with no if_ack;
   - required: if_rd drops after 8 cycles in ISSUE; req0_ack=1 with req0_err=1; req0_rdata is unchanged. A late if_ack pulse then only extends GAP and produces no second ack.
6. Ack and timeout in the same cycle:
   - stimulus: TIMEOUT=8, if_ack arrives on the 8th ISSUE cycle;
   - required: req0_err=0 and if_rdata is captured.
